// File: rtl/alu_oc_pkg.sv
// Shared constants and the entry record for the ALU operand collector.
// Modules size themselves from their own parameters; these are the defaults.
package alu_oc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NSRC_DEF   = 2;
    localparam int DEP_W_DEF  = 4;
    localparam int RS_W_DEF   = 5;
    localparam int CTL_W_DEF  = 51;
    localparam int DEPTH_DEF  = 4;

    // A producer tag of all ones means "no producer": the operand comes from the GRF.
    localparam logic [DEP_W_DEF-1:0] NO_DEP = '1;

    typedef struct packed {
        logic [CTL_W_DEF-1:0]                 ctl;
        logic [NSRC_DEF-1:0][DATA_W_DEF-1:0]  opnd;
        logic [NSRC_DEF-1:0]                  rdy;
        logic [NSRC_DEF-1:0][DEP_W_DEF-1:0]   tag;
    } alu_oc_entry_t;

endpackage

// File: rtl/alu_oc_entry.sv
// One collector slot: holds ctl and source operands, and captures bypassed
// results for any source still waiting on its producer tag.
module alu_oc_entry
    import alu_oc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSRC   = NSRC_DEF,
    parameter int DEP_W  = DEP_W_DEF,
    parameter int CTL_W  = CTL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [CTL_W-1:0]       ldCtl,
    input  logic [NSRC*DATA_W-1:0] ldOpnd,
    input  logic [NSRC-1:0]        ldRdy,
    input  logic [NSRC*DEP_W-1:0]  ldTag,
    input  logic                   byp_valid,
    input  logic [DEP_W-1:0]       byp_tag,
    input  logic [DATA_W-1:0]      byp_data,
    output logic                   valid,
    output logic                   allReady,
    output logic [CTL_W-1:0]       ctl,
    output logic [NSRC*DATA_W-1:0] opnd
);

    localparam logic [DEP_W-1:0] noDepTag = '1;

    logic [NSRC-1:0]       rdy;
    logic [NSRC*DEP_W-1:0] tag;
    logic [NSRC-1:0]       wake;

    // An entry leaving this cycle ignores the broadcast; it is gone next cycle anyway.
    always_comb begin
        wake = '0;
        for (int s = 0; s < NSRC; s++) begin
            wake[s] = valid && !clear && !rdy[s] && byp_valid &&
                      (byp_tag != noDepTag) && (byp_tag == tag[s*DEP_W +: DEP_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload is qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            ctl  <= ldCtl;
            opnd <= ldOpnd;
            rdy  <= ldRdy;
            tag  <= ldTag;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (wake[s]) begin
                    opnd[s*DATA_W +: DATA_W] <= byp_data;
                    rdy[s]                   <= 1'b1;
                end
            end
        end
    end

    assign allReady = &rdy;

endmodule

// File: rtl/alu_operand_collector.sv
// In-order operand collector: resolves sources from immediate, GRF or bypass at
// enqueue, waits on producer tags, and issues the head once all sources are ready.
module alu_operand_collector
    import alu_oc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSRC   = NSRC_DEF,
    parameter int DEP_W  = DEP_W_DEF,
    parameter int RS_W   = RS_W_DEF,
    parameter int CTL_W  = CTL_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTL_W-1:0]         in_ctl,
    input  logic [NSRC*RS_W-1:0]     in_rs,
    input  logic [NSRC*DEP_W-1:0]    in_dep,
    input  logic [NSRC-1:0]          in_use_imm,
    input  logic [DATA_W-1:0]        in_imm,
    output logic [NSRC*RS_W-1:0]     grf_rd_addr,
    input  logic [NSRC*DATA_W-1:0]   grf_rd_data,
    input  logic                     byp_valid,
    input  logic [DEP_W-1:0]         byp_tag,
    input  logic [DATA_W-1:0]        byp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTL_W-1:0]         out_ctl,
    output logic [NSRC*DATA_W-1:0]   out_opnd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DEP_W-1:0] noDepTag = '1;

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high; valid never waits on ready, and an offered output holds until taken.
    logic enq;
    logic deq;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;

    logic [NSRC*DATA_W-1:0] enqOpnd;
    logic [NSRC-1:0]        enqRdy;

    logic [DEPTH-1:0]       entValid;
    logic [DEPTH-1:0]       entAllRdy;
    logic [CTL_W-1:0]       entCtl  [DEPTH];
    logic [NSRC*DATA_W-1:0] entOpnd [DEPTH];

    assign grf_rd_addr = in_rs;
    assign in_ready    = (count != CNT_W'(DEPTH));
    assign enq         = in_valid && in_ready;
    assign out_valid   = entValid[headPtr] && entAllRdy[headPtr];
    assign deq         = out_valid && out_ready;
    assign out_ctl     = out_valid ? entCtl[headPtr]  : '0;
    assign out_opnd    = out_valid ? entOpnd[headPtr] : '0;

    // Source priority at enqueue: immediate, then GRF (no producer), then same-cycle bypass.
    always_comb begin
        enqOpnd = '0;
        enqRdy  = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (in_use_imm[s]) begin
                enqOpnd[s*DATA_W +: DATA_W] = in_imm;
                enqRdy[s]                   = 1'b1;
            end else if (in_dep[s*DEP_W +: DEP_W] == noDepTag) begin
                enqOpnd[s*DATA_W +: DATA_W] = grf_rd_data[s*DATA_W +: DATA_W];
                enqRdy[s]                   = 1'b1;
            end else if (byp_valid && (byp_tag == in_dep[s*DEP_W +: DEP_W])) begin
                enqOpnd[s*DATA_W +: DATA_W] = byp_data;
                enqRdy[s]                   = 1'b1;
            end
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : gEntry
        alu_oc_entry #(
            .DATA_W (DATA_W),
            .NSRC   (NSRC),
            .DEP_W  (DEP_W),
            .CTL_W  (CTL_W)
        ) uEntry (
            .clk       (clk),
            .rst       (rst),
            .load      (enq && (tailPtr == PTR_W'(e))),
            .clear     (deq && (headPtr == PTR_W'(e))),
            .ldCtl     (in_ctl),
            .ldOpnd    (enqOpnd),
            .ldRdy     (enqRdy),
            .ldTag     (in_dep),
            .byp_valid (byp_valid),
            .byp_tag   (byp_tag),
            .byp_data  (byp_data),
            .valid     (entValid[e]),
            .allReady  (entAllRdy[e]),
            .ctl       (entCtl[e]),
            .opnd      (entOpnd[e])
        );
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (enq) tailPtr <= tailPtr + PTR_W'(1);
            if (deq) headPtr <= headPtr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector with default parameters.
module tb_alu_operand_collector;

  localparam int DATA_W = 32;
  localparam int NSRC   = 2;
  localparam int DEP_W  = 4;
  localparam int RS_W   = 5;
  localparam int CTL_W  = 51;
  localparam int DEPTH  = 4;
  localparam int EXP_W  = CTL_W + NSRC * DATA_W;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [CTL_W-1:0]       in_ctl;
  logic [NSRC*RS_W-1:0]   in_rs;
  logic [NSRC*DEP_W-1:0]  in_dep;
  logic [NSRC-1:0]        in_use_imm;
  logic [DATA_W-1:0]      in_imm;
  logic [NSRC*RS_W-1:0]   grf_rd_addr;
  logic [NSRC*DATA_W-1:0] grf_rd_data;
  logic                   byp_valid;
  logic [DEP_W-1:0]       byp_tag;
  logic [DATA_W-1:0]      byp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTL_W-1:0]       out_ctl;
  logic [NSRC*DATA_W-1:0] out_opnd;
  logic [2:0]             count;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] pend_exp;
  int checks;
  int errors;

  alu_operand_collector #(
    .DATA_W(DATA_W), .NSRC(NSRC), .DEP_W(DEP_W), .RS_W(RS_W), .CTL_W(CTL_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl), .in_rs(in_rs),
    .in_dep(in_dep), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .grf_rd_addr(grf_rd_addr), .grf_rd_data(grf_rd_data),
    .byp_valid(byp_valid), .byp_tag(byp_tag), .byp_data(byp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctl(out_ctl), .out_opnd(out_opnd),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_ctl      = '0;
    in_rs       = '0;
    in_dep      = '1;
    in_use_imm  = '0;
    in_imm      = '0;
    grf_rd_data = '0;
    byp_valid   = 1'b0;
    byp_tag     = '0;
    byp_data    = '0;
  endtask

  task automatic set_instr(input logic [CTL_W-1:0] ctl, input logic [1:0] use_imm,
                           input logic [3:0] dep1, input logic [3:0] dep0,
                           input logic [31:0] imm, input logic [31:0] grf1, input logic [31:0] grf0,
                           input logic [31:0] exp1, input logic [31:0] exp0);
    in_valid    = 1'b1;
    in_ctl      = ctl;
    in_rs       = {5'd7, 5'd3};
    in_dep      = {dep1, dep0};
    in_use_imm  = use_imm;
    in_imm      = imm;
    grf_rd_data = {grf1, grf0};
    pend_exp    = {ctl, exp1, exp0};
  endtask

  task automatic set_byp(input logic [3:0] tag, input logic [31:0] data);
    byp_valid = 1'b1;
    byp_tag   = tag;
    byp_data  = data;
  endtask

  // Scoreboard bookkeeping for this cycle, then advance one clock.
  task automatic tick();
    if (in_valid && in_ready) exp_q.push_back(pend_exp);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("deq_empty_q", 32'(exp_q.size()), 1);
      else chk("deq_payload", {out_ctl, out_opnd}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    byp_valid = 1'b0;
  endtask

  task automatic pop();
    chk("pop_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pend_exp  = '0;
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_opnd", out_opnd, 0);
    chk("rst_out_ctl", out_ctl, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // immediate on src0, GRF on src1
    set_instr(51'h0A1, 2'b01, 4'hF, 4'hF, 32'h10, 32'h55, 32'hAAAA, 32'h55, 32'h10);
    chk("grf_addr", grf_rd_addr, {5'd7, 5'd3});
    tick();
    chk("imm_valid", out_valid, 1);
    chk("imm_opnd", out_opnd, {32'h55, 32'h10});
    chk("imm_count", count, 1);
    pop();
    chk("imm_drained_valid", out_valid, 0);
    chk("imm_drained_count", count, 0);
    chk("masked_opnd", out_opnd, 0);

    // src0 waits on tag 3
    set_instr(51'h0B2, 2'b00, 4'hF, 4'h3, 32'h0, 32'h11, 32'h99, 32'h11, 32'hDEAD);
    tick();
    chk("wait_valid", out_valid, 0);
    set_byp(4'hF, 32'hBAD);
    tick();
    chk("nodep_byp_valid", out_valid, 0);
    set_byp(4'h5, 32'hBEEF);
    tick();
    chk("other_tag_valid", out_valid, 0);
    set_byp(4'h3, 32'hDEAD);
    tick();
    chk("wake_valid", out_valid, 1);
    chk("wake_opnd", out_opnd, {32'h11, 32'hDEAD});
    pop();

    // bypass in the enqueue cycle
    set_byp(4'h2, 32'h7);
    set_instr(51'h0C3, 2'b00, 4'hF, 4'h2, 32'h0, 32'h22, 32'h33, 32'h22, 32'h7);
    tick();
    chk("same_cyc_valid", out_valid, 1);
    chk("same_cyc_opnd", out_opnd, {32'h22, 32'h7});
    pop();

    // fill with blocked head, younger entries ready
    set_instr(51'h101, 2'b00, 4'hF, 4'h1, 32'h0, 32'hA1, 32'hA0, 32'hA1, 32'h1111);
    tick();
    set_instr(51'h102, 2'b11, 4'hF, 4'hF, 32'hB0, 32'h0, 32'h0, 32'hB0, 32'hB0);
    tick();
    set_instr(51'h103, 2'b00, 4'hF, 4'hF, 32'h0, 32'hC1, 32'hC0, 32'hC1, 32'hC0);
    tick();
    set_instr(51'h104, 2'b10, 4'hF, 4'hF, 32'hD1, 32'h0, 32'hD0, 32'hD1, 32'hD0);
    tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    chk("blocked_valid", out_valid, 0);
    out_ready = 1'b1;
    set_instr(51'h1FF, 2'b11, 4'hF, 4'hF, 32'hFF, 32'h0, 32'h0, 32'hFF, 32'hFF);
    tick();
    tick();
    chk("blocked_still", out_valid, 0);
    chk("full_no_accept", count, 4);
    out_ready = 1'b0;
    set_byp(4'h1, 32'h1111);
    tick();
    chk("head_woke", out_valid, 1);
    chk("head_woke_count", count, 4);
    for (int i = 0; i < 4; i++) pop();
    chk("order_drained", count, 0);

    // wrap: full, deq only, then enq+deq together
    for (int i = 0; i < 4; i++) begin
      set_instr(51'h201 + 51'(i), 2'b11, 4'hF, 4'hF, 32'h201 + i, 32'h0, 32'h0,
                32'h201 + i, 32'h201 + i);
      tick();
    end
    chk("wrap_full_count", count, 4);
    chk("wrap_full_ready", in_ready, 0);
    out_ready = 1'b1;
    set_instr(51'h2E1, 2'b11, 4'hF, 4'hF, 32'h2E1, 32'h0, 32'h0, 32'h2E1, 32'h2E1);
    tick();
    chk("wrap_deq_count", count, 3);
    chk("wrap_ready_rise", in_ready, 1);
    set_instr(51'h2E1, 2'b11, 4'hF, 4'hF, 32'h2E1, 32'h0, 32'h0, 32'h2E1, 32'h2E1);
    tick();
    chk("simul_count", count, 3);
    out_ready = 1'b0;
    set_instr(51'h2E2, 2'b11, 4'hF, 4'hF, 32'h2E2, 32'h0, 32'h0, 32'h2E2, 32'h2E2);
    tick();
    chk("refill_count", count, 4);
    for (int i = 0; i < 4; i++) pop();
    chk("wrap_drained", count, 0);

    // reset with entries waiting on tag 9
    for (int i = 0; i < 3; i++) begin
      set_instr(51'h301 + 51'(i), 2'b00, 4'hF, 4'h9, 32'h0, 32'h31, 32'h30, 32'h31, 32'h999);
      tick();
    end
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_byp(4'h9, 32'h999);
    tick();
    chk("post_rst_byp_valid", out_valid, 0);
    chk("post_rst_byp_count", count, 0);
    set_instr(51'h401, 2'b01, 4'hF, 4'hF, 32'h44, 32'h45, 32'h0, 32'h45, 32'h44);
    tick();
    chk("post_rst_alive", out_valid, 1);
    pop();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
